// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_pkg
// Description : Shared constants, types and decode helpers for the RV32M
//               multiply/divide execute unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_pkg;

  // R-type opcode and the funct7 value that selects the M extension
  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNC7_MEXT    = 7'b0000001;

  typedef logic [2:0] func3_t;

  localparam func3_t INST_MUL    = 3'b000;
  localparam func3_t INST_MULH   = 3'b001;
  localparam func3_t INST_MULHSU = 3'b010;
  localparam func3_t INST_MULHU  = 3'b011;
  localparam func3_t INST_DIV    = 3'b100;
  localparam func3_t INST_DIVU   = 3'b101;
  localparam func3_t INST_REM    = 3'b110;
  localparam func3_t INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  // rs1 is interpreted as two's complement for these operations
  function automatic logic op1_signed(input func3_t f);
    return (f == INST_MUL) || (f == INST_MULH) || (f == INST_MULHSU) ||
           (f == INST_DIV) || (f == INST_REM);
  endfunction

  // rs2 is interpreted as two's complement for these operations
  function automatic logic op2_signed(input func3_t f);
    return (f == INST_MUL) || (f == INST_MULH) ||
           (f == INST_DIV) || (f == INST_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_if
// Description : Request/response bundle between the EX stage and the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            start_in;
  func3_t          func3_in;
  logic [XLEN-1:0] op1_in;
  logic [XLEN-1:0] op2_in;
  logic [4:0]      rd_addr_in;
  logic            flush_in;
  logic [XLEN-1:0] result_out;
  logic [4:0]      rd_addr_out;
  logic            done_out;
  logic            busy_out;
  logic            stall_req_out;

  // Pipeline side: issues the operation and consumes the result
  modport master (
    output start_in, func3_in, op1_in, op2_in, rd_addr_in, flush_in,
    input  result_out, rd_addr_out, done_out, busy_out, stall_req_out
  );

  // Execute-unit side
  modport slave (
    input  start_in, func3_in, op1_in, op2_in, rd_addr_in, flush_in,
    output result_out, rd_addr_out, done_out, busy_out, stall_req_out
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_core
// Description : Iterative datapath: shift-add multiply into a 2*XLEN
//               accumulator or restoring shift-subtract divide, one bit per
//               step, plus the iteration counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_core #(
  parameter int XLEN = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            load_in,
  input  wire logic            step_in,
  input  wire logic            div_in,
  input  wire logic [XLEN-1:0] a_in,
  input  wire logic [XLEN-1:0] b_in,
  output logic                 last_out,
  output logic [XLEN-1:0]      hi_out,
  output logic [XLEN-1:0]      lo_out
);

  localparam int CW = $clog2(XLEN);

  // hi: product high half / partial remainder; lo: multiplier / quotient
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [CW-1:0]   r_count;
  logic            r_div;

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_sub;
  logic            w_ge;

  // Multiply: add the multiplicand when the current multiplier bit is set
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide: partial remainder shifted left with the next dividend bit;
  // it needs XLEN+1 bits before the trial subtraction
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  // A successful subtraction always leaves a value below the divisor
  assign w_sub   = XLEN'(w_shift - {1'b0, r_b});

  // Load operands, then advance one bit of multiply or divide per step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_count <= '0;
      r_div   <= 1'b0;
    end else if (load_in) begin
      r_hi    <= '0;
      r_lo    <= a_in;
      r_b     <= b_in;
      r_div   <= div_in;
      r_count <= CW'(XLEN - 1);
    end else if (step_in) begin
      if (r_div) begin
        r_hi <= w_ge ? w_sub : w_shift[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_ge};
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
      r_count <= r_count - CW'(1);
    end
  end

  assign last_out = (r_count == '0);
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : RV32M execute unit. Sequences the iterative core, resolves
//               divide-by-zero / overflow / fast-multiply in one cycle, and
//               applies the sign fixup before the one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_FAST = 0
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ex_muldiv_if.slave  bus
);

  muldiv_state_e   r_state;
  muldiv_state_e   w_next;

  func3_t          r_func3;
  logic [4:0]      r_rd;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  logic            w_accept;
  logic            w_s1;
  logic            w_s2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_is_div;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_fast;
  logic            w_special;
  logic [XLEN-1:0] w_special_val;
  logic [XLEN-1:0] w_fast_val;
  logic [XLEN-1:0] w_fix_val;

  logic            w_core_last;
  logic [XLEN-1:0] w_core_hi;
  logic [XLEN-1:0] w_core_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;

  assign w_accept   = (r_state == ST_IDLE) && bus.start_in && !bus.flush_in;
  assign w_s1       = op1_signed(bus.func3_in) && bus.op1_in[XLEN-1];
  assign w_s2       = op2_signed(bus.func3_in) && bus.op2_in[XLEN-1];
  assign w_mag1     = w_s1 ? -bus.op1_in : bus.op1_in;
  assign w_mag2     = w_s2 ? -bus.op2_in : bus.op2_in;
  assign w_is_div   = bus.func3_in[2];
  assign w_div_zero = w_is_div && (bus.op2_in == '0);
  assign w_ovf      = ((bus.func3_in == INST_DIV) || (bus.func3_in == INST_REM)) &&
                      (bus.op1_in == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2_in == '1);
  assign w_fast     = (MUL_FAST != 0) && !w_is_div;
  assign w_special  = w_div_zero || w_ovf || w_fast;

  // Single-cycle product: both operands extended to 2*XLEN per signedness,
  // the truncated product is then exact for the full-width result
  if (MUL_FAST != 0) begin : g_fast_mul
    logic [2*XLEN-1:0] w_ext1;
    logic [2*XLEN-1:0] w_ext2;
    logic [2*XLEN-1:0] w_full;
    assign w_ext1     = {{XLEN{w_s1}}, bus.op1_in};
    assign w_ext2     = {{XLEN{w_s2}}, bus.op2_in};
    assign w_full     = w_ext1 * w_ext2;
    assign w_fast_val = (bus.func3_in == INST_MUL) ? w_full[XLEN-1:0]
                                                   : w_full[2*XLEN-1:XLEN];
  end else begin : g_iter_mul
    assign w_fast_val = '0;
  end

  // Result for operations that bypass the iterative datapath
  always_comb begin
    w_special_val = w_fast_val;
    if (w_div_zero) begin
      w_special_val = bus.func3_in[1] ? bus.op1_in : '1;
    end else if (w_ovf) begin
      w_special_val = bus.func3_in[1] ? '0 : bus.op1_in;
    end
  end

  ex_muldiv_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_in  (w_accept && !w_special),
    .step_in  ((r_state == ST_CALC) && !bus.flush_in),
    .div_in   (w_is_div),
    .a_in     (w_mag1),
    .b_in     (w_mag2),
    .last_out (w_core_last),
    .hi_out   (w_core_hi),
    .lo_out   (w_core_lo)
  );

  assign w_prod   = {w_core_hi, w_core_lo};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quot   = r_neg_q ? -w_core_lo : w_core_lo;
  assign w_rem    = r_neg_r ? -w_core_hi : w_core_hi;

  // Sign fixup and half/quotient/remainder selection at the end of iteration
  always_comb begin
    w_fix_val = w_rem;
    case (r_func3)
      INST_MUL:                          w_fix_val = w_prod_s[XLEN-1:0];
      INST_MULH, INST_MULHSU, INST_MULHU: w_fix_val = w_prod_s[2*XLEN-1:XLEN];
      INST_DIV, INST_DIVU:               w_fix_val = w_quot;
      default:                           w_fix_val = w_rem;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; flush aborts from any state
  always_comb begin
    w_next = r_state;
    if (bus.flush_in) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start_in) w_next = w_special ? ST_DONE : ST_CALC;
        ST_CALC: if (w_core_last)  w_next = ST_FIX;
        ST_FIX:                    w_next = ST_DONE;
        default:                   w_next = ST_IDLE;
      endcase
    end
  end

  // Capture operation context on accept and the result when it is known
  always_ff @(posedge clk) begin
    if (rst) begin
      r_func3  <= '0;
      r_rd     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      if (w_accept) begin
        r_func3 <= bus.func3_in;
        r_rd    <= bus.rd_addr_in;
        r_neg_q <= w_s1 ^ w_s2;
        r_neg_r <= w_s1;
        if (w_special) begin
          r_result <= w_special_val;
          r_rd_out <= bus.rd_addr_in;
        end
      end
      if ((r_state == ST_FIX) && !bus.flush_in) begin
        r_result <= w_fix_val;
        r_rd_out <= r_rd;
      end
    end
  end

  assign bus.result_out    = r_result;
  assign bus.rd_addr_out   = r_rd_out;
  assign bus.done_out      = (r_state == ST_DONE) && !bus.flush_in;
  assign bus.busy_out      = (r_state != ST_IDLE);
  assign bus.stall_req_out = (r_state == ST_CALC) || (r_state == ST_FIX) || w_accept;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Self-checking bench for ex_muldiv (iterative and fast
//               multiply instances) against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  f3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  rd;
  logic        sel_fast;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(XLEN)) bus  ();
  ex_muldiv_if #(.XLEN(XLEN)) fbus ();

  assign bus.start_in    = start && !sel_fast;
  assign bus.func3_in    = f3;
  assign bus.op1_in      = op1;
  assign bus.op2_in      = op2;
  assign bus.rd_addr_in  = rd;
  assign bus.flush_in    = flush;
  assign fbus.start_in   = start && sel_fast;
  assign fbus.func3_in   = f3;
  assign fbus.op1_in     = op1;
  assign fbus.op2_in     = op2;
  assign fbus.rd_addr_in = rd;
  assign fbus.flush_in   = flush;

  ex_muldiv #(.XLEN(XLEN), .MUL_FAST(0)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  ex_muldiv #(.XLEN(XLEN), .MUL_FAST(1)) u_fast (.clk(clk), .rst(rst), .bus(fbus));

  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_done;
  logic        o_busy;
  logic        o_stall;

  assign o_result = sel_fast ? fbus.result_out    : bus.result_out;
  assign o_rd     = sel_fast ? fbus.rd_addr_out   : bus.rd_addr_out;
  assign o_done   = sel_fast ? fbus.done_out      : bus.done_out;
  assign o_busy   = sel_fast ? fbus.busy_out      : bus.busy_out;
  assign o_stall  = sel_fast ? fbus.stall_req_out : bus.stall_req_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RV32M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] fn, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint          p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (fn)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Cycle (counted from acceptance) in which done_out is expected
  function automatic int ref_latency(input logic [2:0] fn, input logic [31:0] a,
                                     input logic [31:0] b, input logic fast);
    if (fn[2]) begin
      if (b == 32'd0) return 1;
      if ((fn == 3'd4 || fn == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 2;
    end
    return fast ? 1 : XLEN + 2;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation (entered and left one time unit after a rising edge)
  task automatic do_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] b);
    int          cyc;
    int          stall_err;
    logic        got;
    logic [31:0] exp_res;
    int          exp_lat;
    logic [4:0]  r;
    exp_res = ref_result(fn, a, b);
    exp_lat = ref_latency(fn, a, b, sel_fast);
    r       = 5'($urandom_range(1, 31));
    start = 1'b1; f3 = fn; op1 = a; op2 = b; rd = r;
    #1;
    cyc       = 0;
    stall_err = (o_stall !== 1'b1) ? 1 : 0;
    got       = 1'b0;
    while (!got && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (o_done === 1'b1) got = 1'b1;
      else if (o_stall !== 1'b1) stall_err++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " result"}, o_result, exp_res);
    check({tag, " rd"}, 32'(o_rd), 32'(r));
    check({tag, " stall"}, 32'(stall_err) + 32'(o_stall), 32'd0);
    last_res = exp_res;
    // start still held through the done cycle must not launch a second op
    @(posedge clk); #1;
    check({tag, " single pulse"}, {30'd0, o_busy, o_done}, 32'd0);
    start = 1'b0;
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; op1 = '0; op2 = '0; rd = '0;
    sel_fast = 1'b0; last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset result", o_result, 32'd0);
    check("reset rd", 32'(o_rd), 32'd0);
    check("reset flags", {29'd0, o_done, o_busy, o_stall}, 32'd0);

    // Directed cases
    do_op("mul 7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    do_op("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhu max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu -1x2", 3'd2, 32'hFFFF_FFFF, 32'd2);
    do_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op("divu 100/7", 3'd5, 32'd100, 32'd7);
    do_op("remu 100/7", 3'd7, 32'd100, 32'd7);
    do_op("div 5/0", 3'd4, 32'd5, 32'd0);
    do_op("remu 5/0", 3'd7, 32'd5, 32'd0);
    do_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      fn = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      do_op($sformatf("rand%0d f3=%0d", i, fn), fn, a, b);
    end

    // Flush in cycle 10 of a divide
    start = 1'b1; f3 = 3'd4; op1 = 32'd1000; op2 = 32'd3; rd = 5'd9;
    ndone = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (o_done === 1'b1) ndone++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    if (o_done === 1'b1) ndone++;
    check("flush no done", 32'(ndone), 32'd0);
    check("flush idle", 32'(o_busy), 32'd0);
    check("flush keeps result", o_result, last_res);
    @(posedge clk); #1;
    do_op("mul 3x4 after flush", 3'd0, 32'd3, 32'd4);

    // Reset in the middle of CALC
    start = 1'b1; f3 = 3'd0; op1 = 32'd11; op2 = 32'd13; rd = 5'd17;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("midrst result", o_result, 32'd0);
    check("midrst rd", 32'(o_rd), 32'd0);
    check("midrst flags", {29'd0, o_done, o_busy, o_stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fast multiply instance
    sel_fast = 1'b1;
    do_op("fast mul 6x7", 3'd0, 32'd6, 32'd7);
    do_op("fast mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("fast mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2);
    do_op("fast divu", 3'd5, 32'd100, 32'd7);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] fn;
      fn = 3'($urandom_range(0, 3));
      do_op($sformatf("fast rand%0d f3=%0d", i, fn), fn, rand_operand(), rand_operand());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Parametrised iterative RV32M execute unit, a sibling of the integer EX stage. It handles opcode INST_TYPE_R_M with func7 = 0000001 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). While busy it stalls the pipeline through stall_req_out. It returns the result and destination register with a one-cycle done pulse, which EX muxes onto op_out.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
MUL_FAST, 0, 1 = multiplies complete via single-cycle combinational product; 0 = iterative shift-add.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start_in  input  1  M-op present in EX; held by pipeline until done_out
func3_in  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op1_in  input  XLEN  rs1 value
op2_in  input  XLEN  rs2 value
rd_addr_in  input  5  destination register
flush_in  input  1  branch_taken/flush from EX; aborts operation
result_out  output  XLEN  registered result, valid when done_out=1
rd_addr_out  output  5  registered rd, valid when done_out=1
done_out  output  1  one-cycle completion pulse
busy_out  output  1  state not IDLE
stall_req_out  output  1  hold IF/ID/EX stages

Behaviour:
- Reset: one clock; rst is synchronous and active-high, sampled on posedge clk. All outputs 0, state IDLE, counter 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start_in=1 and flush_in=0 (cycle 0): latch func3 and rd, and the magnitudes of op1/op2 per signedness.
  - Signed ops: MUL*, DIV, REM; MULHSU treats op1 as signed and op2 as unsigned.
  - Latch sign flags. Go to CALC with counter = XLEN-1.
- Special cases decided in IDLE go directly to DONE (done_out in cycle 1):
  - divisor 0: DIV/DIVU -> all-ones; REM/REMU -> op1_in.
  - signed overflow (op1 = -2^(XLEN-1), op2 = -1): DIV -> op1_in; REM -> 0.
  - MUL_FAST=1 and any multiply: full 2*XLEN signed/unsigned product computed combinationally, selected half latched.
- CALC, one iteration per cycle:
  - multiply: shift-add into a 2*XLEN accumulator.
  - divide: restoring shift-subtract, remainder XLEN+1 bits.
  - counter decrements; at 0 go to FIX.
- FIX (one cycle):
  - negate product if the sign flags differ; select low half (MUL) or high half (MULH*).
  - quotient sign = s1^s2; remainder sign = s1.
  - register result_out; go to DONE.
- DONE: done_out=1 and result_out/rd_addr_out valid for this one cycle; next state IDLE unconditionally. start_in seen in DONE is the completing instruction and is ignored.
- Latency, iterative path: done_out in cycle XLEN+2 after acceptance (34 for XLEN=32).
- stall_req_out = (state==CALC || state==FIX) || (state==IDLE && start_in && !flush_in). It is 0 in DONE, so the pipeline advances on the done cycle.
- busy_out = (state != IDLE).
- flush_in=1 in any state: next state IDLE, no done_out, result_out keeps its old value. flush has priority over start_in.
- rst mid-operation: IDLE next cycle, outputs 0, no done pulse.
- Width rules: all arithmetic is unsigned on magnitudes. Results truncate to XLEN; the MULH* high half is bits [2*XLEN-1:XLEN].

Decomposition:
- Shared define.v gains INST_MUL..INST_REMU func3 constants, the func7 M-ext value 7'b0000001, and the state encodings.
- One natural sub-module: ex_muldiv_core. It holds the XLEN-parametrised accumulator/remainder register, the counter and the per-iteration add/subtract datapath.
- The FSM, special-case detection and sign fixup stay in ex_muldiv.

Test Plan:
- MUL 7 x -3 (XLEN=32, MUL_FAST=0) -> done_out in cycle 34; result 0xFFFFFFEB; stall_req_out high cycles 0-33, low in 34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF, REMU 5 / 0 -> 5, DIV 0x80000000 / -1 -> 0x80000000, REM 0x80000000 / -1 -> 0; each with done_out in cycle 1.
- flush_in asserted in cycle 10 of a DIV -> IDLE in cycle 11; no done_out; a new MUL 3 x 4 started in cycle 12 -> 12 in cycle 46.
- rst asserted mid-CALC -> all outputs 0 next cycle. Separately, start_in held high through DONE is not re-accepted (exactly one done pulse). Separately, MUL_FAST=1: MUL 6 x 7 -> 42 with done in cycle 1.
